// File: rtl/data_mem_pkg.sv
// Shared constants and FSM state type for the data memory stage.
package data_mem_pkg;
   localparam int DMEM_DATA_W = 16;
   localparam int DMEM_ADDR_W = 16;
   localparam int WCNT_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write enable and registered read.
// No reset on the array or its output register so it maps onto block RAM.
module dmem_array #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [DATA_W-1:0]     i_wdata,
   output logic [DATA_W-1:0]     o_rdata
);
   logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/data_mem_unit.sv
// Word-addressed data memory stage with programmable wait states and a
// ready/error completion handshake toward the core.
module data_mem_unit
   import data_mem_pkg::*;
#(
   parameter int DATA_W      = DMEM_DATA_W,
   parameter int ADDR_W      = DMEM_ADDR_W,
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] d_mem_addr,
   input  logic [DATA_W-1:0] d_mem_wr_data,
   input  logic              d_mem_rd_ctrl,
   input  logic              d_mem_wr_ctrl,
   output logic [DATA_W-1:0] d_mem_rd_data,
   output logic              d_mem_ready,
   output logic              d_mem_err
);
   localparam logic [WCNT_W-1:0] WS_INIT = WCNT_W'(WAIT_STATES);

   dmem_state_e             r_state, w_state_nxt;
   logic [WCNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [DEPTH_LOG2-1:0]   r_addr;
   logic [DATA_W-1:0]       r_wdata;
   logic                    r_is_wr;
   logic                    r_bad;
   logic                    r_ready;
   logic                    r_err;
   logic                    r_rd_valid;

   logic                    w_req;
   logic                    w_oor;
   logic                    w_take;
   logic                    w_done;
   logic                    w_ram_we;
   logic                    w_ram_re;
   logic [DATA_W-1:0]       w_ram_q;

   assign w_req = d_mem_rd_ctrl | d_mem_wr_ctrl;

   generate
      if (ADDR_W > DEPTH_LOG2) begin : g_range
         assign w_oor = |d_mem_addr[ADDR_W-1:DEPTH_LOG2];
      end else begin : g_no_range
         assign w_oor = 1'b0;
      end
   endgenerate

   // The closing edge of ACCESS also accepts a new request, so a held
   // request stream completes one access every WAIT_STATES+1 cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) w_take = 1'b1;
         end
         S_WAIT: begin
            if (r_cnt <= WCNT_W'(1)) w_state_nxt = S_ACCESS;
            if (r_cnt != '0) w_cnt_nxt = r_cnt - WCNT_W'(1);
         end
         S_ACCESS: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            if (w_req) w_take = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      if (w_take) begin
         if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_INIT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_is_wr    <= 1'b0;
         r_bad      <= 1'b0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_done;
         r_err   <= w_done & r_bad;
         if (w_take) begin
            r_addr  <= d_mem_addr[DEPTH_LOG2-1:0];
            r_wdata <= d_mem_wr_data;
            r_is_wr <= d_mem_wr_ctrl;
            r_bad   <= (d_mem_rd_ctrl & d_mem_wr_ctrl) | w_oor;
         end
         // Read data register: cleared by errors, refreshed by good reads,
         // left alone by writes.
         if (w_done) begin
            if (r_bad)         r_rd_valid <= 1'b0;
            else if (!r_is_wr) r_rd_valid <= 1'b1;
         end
      end
   end

   assign w_ram_we = w_done & ~r_bad & r_is_wr;
   assign w_ram_re = w_done & ~r_bad & ~r_is_wr;

   dmem_array #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_q)
   );

   assign d_mem_rd_data = r_rd_valid ? w_ram_q : '0;
   assign d_mem_ready   = r_ready;
   assign d_mem_err     = r_err;
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances (1, 0 and 3 wait states) checked
// against a word-array memory model and the completion latency rule.
module tb_data_mem_unit;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] addr  [NI];
   logic [15:0] wdata [NI];
   logic [15:0] rdata [NI];
   logic        rd    [NI];
   logic        wr    [NI];
   logic        rdy   [NI];
   logic        err   [NI];

   logic [15:0] mem    [NI][256];
   logic [15:0] exp_rd [NI];
   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   data_mem_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst(rst), .d_mem_addr(addr[0]), .d_mem_wr_data(wdata[0]),
      .d_mem_rd_ctrl(rd[0]), .d_mem_wr_ctrl(wr[0]), .d_mem_rd_data(rdata[0]),
      .d_mem_ready(rdy[0]), .d_mem_err(err[0]));
   data_mem_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .d_mem_addr(addr[1]), .d_mem_wr_data(wdata[1]),
      .d_mem_rd_ctrl(rd[1]), .d_mem_wr_ctrl(wr[1]), .d_mem_rd_data(rdata[1]),
      .d_mem_ready(rdy[1]), .d_mem_err(err[1]));
   data_mem_unit #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst), .d_mem_addr(addr[2]), .d_mem_wr_data(wdata[2]),
      .d_mem_rd_ctrl(rd[2]), .d_mem_wr_ctrl(wr[2]), .d_mem_rd_data(rdata[2]),
      .d_mem_ready(rdy[2]), .d_mem_err(err[2]));

   function automatic int ws_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 3;
   endfunction

   task automatic idle_inputs(input int i);
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
   endtask

   // One complete transaction: request on one edge, optional input noise
   // during WAIT, then latency, ready/err and read data checked.
   task automatic run_access(input int i, input bit r, input bit w,
                             input logic [15:0] a, input logic [15:0] d,
                             input bit scramble);
      int  ws;
      bit  bad;
      ws = ws_of(i);
      @(negedge clk);
      rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d;
      bad = (r && w) || (a[15:8] != 8'h00);
      if (bad)    exp_rd[i] = 16'h0000;
      else if (r) exp_rd[i] = mem[i][a[7:0]];
      else        mem[i][a[7:0]] = d;
      for (int k = 1; k <= ws + 1; k++) begin
         @(negedge clk);
         if (scramble && k <= ws) begin
            rd[i] = 1'($urandom); wr[i] = 1'($urandom);
            addr[i] = 16'($urandom); wdata[i] = 16'($urandom);
         end else begin
            idle_inputs(i);
         end
         @(posedge clk); #1;
         tests_run++;
         if (rdy[i] !== (k == ws + 1)) begin
            tests_failed++;
            $display("FAIL ready_latency inst%0d edge%0d: got %b expected %b", i, k, rdy[i], (k == ws + 1));
         end
      end
      tests_run++;
      if (err[i] !== bad) begin
         tests_failed++;
         $display("FAIL err_flag inst%0d addr %h: got %b expected %b", i, a, err[i], bad);
      end
      tests_run++;
      if (rdata[i] !== exp_rd[i]) begin
         tests_failed++;
         $display("FAIL rd_data inst%0d addr %h: got %h expected %h", i, a, rdata[i], exp_rd[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (rdy[i] !== 1'b0 || err[i] !== 1'b0) begin
         tests_failed++;
         $display("FAIL pulse_width inst%0d: got rdy %b err %b expected 0 0", i, rdy[i], err[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            rd[i] = 1'($urandom); wr[i] = 1'($urandom);
            addr[i] = 16'($urandom); wdata[i] = 16'($urandom);
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
         tests_run++;
         if (rdy[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_values inst%0d: got rdy %b err %b data %h expected 0 0 0000", i, rdy[i], err[i], rdata[i]);
         end
         exp_rd[i] = 16'h0000;
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) idle_inputs(i);
      rst = 1'b1;
   endtask

   task automatic test_preload();
      for (int i = 0; i < NI; i++)
         for (int a = 0; a < 16; a++)
            run_access(i, 1'b0, 1'b1, 16'(a), 16'($urandom), 1'b0);
   endtask

   task automatic test_write_read();
      run_access(0, 1'b0, 1'b1, 16'h0012, 16'hBEEF, 1'b0);
      run_access(0, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b0);
      tests_run++;
      if (rdata[0] !== 16'hBEEF) begin
         tests_failed++;
         $display("FAIL write_read: got %h expected beef", rdata[0]);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      rd[1] = 1'b1; addr[1] = 16'h0001;
      @(posedge clk);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         if (j < 3) addr[1] = 16'(j + 1);
         else       idle_inputs(1);
         @(posedge clk); #1;
         tests_run++;
         if (rdy[1] !== 1'b1 || err[1] !== 1'b0 || rdata[1] !== mem[1][j]) begin
            tests_failed++;
            $display("FAIL back_to_back word%0d: got rdy %b err %b data %h expected 1 0 %h", j, rdy[1], err[1], rdata[1], mem[1][j]);
         end
      end
      exp_rd[1] = mem[1][3];
      @(posedge clk); #1;
      tests_run++;
      if (rdy[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL back_to_back_end: got rdy %b expected 0", rdy[1]);
      end
   endtask

   task automatic test_errors();
      run_access(0, 1'b0, 1'b1, 16'h0100, 16'h5555, 1'b0);
      run_access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      run_access(0, 1'b1, 1'b1, 16'h0007, 16'hA5A5, 1'b0);
      run_access(0, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0);
      run_access(1, 1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0);
      run_access(2, 1'b1, 1'b1, 16'h0009, 16'h0F0F, 1'b0);
      run_access(2, 1'b1, 1'b0, 16'h0009, 16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid_access();
      logic [15:0] prior;
      prior = mem[2][5];
      if (prior == 16'h1234) begin
         prior = 16'h4321;
         run_access(2, 1'b0, 1'b1, 16'h0005, prior, 1'b0);
      end
      @(negedge clk);
      wr[2] = 1'b1; addr[2] = 16'h0005; wdata[2] = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      idle_inputs(2);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NI; i++) exp_rd[i] = 16'h0000;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         tests_run++;
         if (rdy[2] !== 1'b0 || rdata[2] !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid_hold cyc%0d: got rdy %b data %h expected 0 0000", c, rdy[2], rdata[2]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         tests_run++;
         if (rdy[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_ready cyc%0d: got %b expected 0", c, rdy[2]);
         end
      end
      run_access(2, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
      tests_run++;
      if (rdata[2] !== prior) begin
         tests_failed++;
         $display("FAIL reset_mid_dropped_write: got %h expected %h", rdata[2], prior);
      end
   endtask

   task automatic test_input_stability();
      run_access(2, 1'b0, 1'b1, 16'h000A, 16'hC0DE, 1'b1);
      run_access(2, 1'b1, 1'b0, 16'h000A, 16'h0000, 1'b1);
      run_access(0, 1'b0, 1'b1, 16'h000B, 16'h7E57, 1'b1);
      run_access(0, 1'b1, 1'b0, 16'h000B, 16'h0000, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int          i;
         int          op;
         logic [15:0] a;
         i  = int'($urandom_range(0, NI - 1));
         op = int'($urandom_range(0, 9));
         if ($urandom_range(0, 9) == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
         else                           a = 16'($urandom_range(0, 15));
         run_access(i, (op < 5) || (op == 9), (op >= 5), a, 16'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         idle_inputs(i);
         exp_rd[i] = 16'h0000;
      end
      test_reset();
      test_preload();
      test_write_read();
      test_back_to_back();
      test_errors();
      test_reset_mid_access();
      test_input_stability();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
